// File: rtl/uart_tx_ctrl.sv
// UART transmit framer: serializes one latched word per frame as
// start bit, DATA_WIDTH data bits LSB first, optional parity bit, stop bit.
module uart_tx_ctrl #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  par_en,
    input  logic                  PAR_bit,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    par_en_q;
    logic                    tx_q;
    logic                    busy_q;
    logic [CNT_W-1:0]        cnt_inc;

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Outputs are loaded one edge ahead so TX_OUT/Busy always reflect the current state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            par_en_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (Data_Valid) begin
                        data_q   <= P_DATA;
                        par_en_q <= par_en;
                        state_q  <= START;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                START: begin
                    state_q <= DATA;
                    cnt_q   <= '0;
                    tx_q    <= data_q[0];
                end
                DATA: begin
                    if (cnt_q == LAST_BIT) begin
                        cnt_q <= '0;
                        if (par_en_q) begin
                            state_q <= PARITY;
                            tx_q    <= PAR_bit;
                        end else begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_inc;
                        tx_q  <= data_q[cnt_inc];
                    end
                end
                PARITY: begin
                    state_q <= STOP;
                    tx_q    <= 1'b1;
                end
                STOP: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: the driver queues the expected {Busy,TX_OUT}
// for every cycle it drives; a monitor pops and compares on each falling edge.
module tb_uart_tx_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       par_en;
    logic       PAR_bit;
    logic       TX_OUT;
    logic       Busy;

    logic [1:0] exp_q[$];
    int         tag_q[$];
    int         n_cmp;
    int         n_bad;
    int         step_no;

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .par_en     (par_en),
        .PAR_bit    (PAR_bit),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected {busy,tx} entry per cycle, compared mid-cycle.
    initial begin
        logic [1:0] e;
        int         t;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                n_cmp++;
                if ({Busy, TX_OUT} !== e) begin
                    n_bad++;
                    $display("FAIL cycle%0d {Busy,TX_OUT}: got %b%b want %b", t, Busy, TX_OUT, e);
                end
            end
        end
    end

    // Drive one cycle of inputs and queue what the outputs must show during it.
    task automatic step(input logic rn, input logic dv, input logic [7:0] d,
                        input logic pe, input logic pb, input logic eb, input logic et);
        rst_n      = rn;
        Data_Valid = dv;
        P_DATA     = d;
        par_en     = pe;
        PAR_bit    = pb;
        exp_q.push_back({eb, et});
        tag_q.push_back(step_no);
        step_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Issue one frame; bits holds the hand-computed line sequence, first bit in position n-1.
    // inj_idx pulses Data_Valid with 0xFF mid-frame; rst_idx pulls reset in that frame cycle.
    task automatic send(input logic [7:0] d, input logic pe, input logic pb,
                        input logic [15:0] bits, input int n,
                        input int inj_idx, input int rst_idx);
        logic b;
        step(1'b1, 1'b1, d, pe, pb, 1'b0, 1'b1);
        for (int i = 0; i < n; i++) begin
            b = bits[n-1-i];
            if (i == rst_idx) begin
                step(1'b0, 1'b1, 8'h5A, pe, pb, 1'b1, b);
                return;
            end
            if (i == inj_idx) step(1'b1, 1'b1, 8'hFF, ~pe, pb, 1'b1, b);
            else              step(1'b1, 1'b0, ~d, ~pe, pb, 1'b1, b);
        end
    endtask

    initial begin
        int guard;
        n_cmp      = 0;
        n_bad      = 0;
        step_no    = 0;
        rst_n      = 1'b0;
        Data_Valid = 1'b0;
        P_DATA     = 8'h00;
        par_en     = 1'b0;
        PAR_bit    = 1'b0;
        @(posedge clk);
        #1;

        // Reset held, Data_Valid ignored while in reset, then 5 idle cycles.
        step(1'b0, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(5);

        // 0xA5 with parity bit 0: 0,1,0,1,0,0,1,0,1,0,1.
        send(8'hA5, 1'b1, 1'b0, 16'(11'b01010010101), 11, -1, -1);
        idle(2);

        // 0x3C without parity: 0,0,0,1,1,1,1,0,0,1.
        send(8'h3C, 1'b0, 1'b1, 16'(10'b0001111001), 10, -1, -1);
        idle(1);

        // 0x01 with parity 1; 0xFF pulse in the 4th data cycle must be ignored.
        send(8'h01, 1'b1, 1'b1, 16'(11'b01000000011), 11, 4, -1);
        idle(3);

        // Back-to-back: 0x96 no parity, then 0x81 parity 0 accepted in first idle cycle.
        send(8'h96, 1'b0, 1'b0, 16'(10'b0011010011), 10, -1, -1);
        send(8'h81, 1'b1, 1'b0, 16'(11'b01000000101), 11, -1, -1);
        idle(2);

        // 0x00 aborted by reset in the 5th data cycle (frame index 5), then
        // 0x5A parity 0 accepted on the first edge out of reset.
        send(8'h00, 1'b0, 1'b0, 16'(10'b0000000001), 10, -1, 5);
        send(8'h5A, 1'b1, 1'b0, 16'(11'b00101101001), 11, -1, -1);
        idle(2);

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        #1;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
